// File: rtl/htd_arb.sv
// htd_arb: 4-port round-robin packet arbiter with one-cycle registered data merge.
// Optional HTD_ARB_STATS_EN adds packet and timeout release counters.
module htd_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [3:0]                    i_req,
    output logic [3:0]                    o_gnt,
    input  logic [4*(DATA_WIDTH+1)-1:0]   iv_data,
    input  logic [3:0]                    i_data_wr,
    output logic [DATA_WIDTH:0]           ov_data,
    output logic                          o_data_wr
`ifdef HTD_ARB_STATS_EN
    ,
    output logic [15:0]                   ov_pkt_cnt,
    output logic [15:0]                   ov_timeout_cnt
`endif
);

    localparam int TW = DATA_WIDTH + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_last;
    logic [1:0]      w_win;
    logic            w_win_vld;
    logic [1:0]      w_gidx;
    logic            w_req_g, w_wr_g;
    logic [TW-1:0]   w_data_g;
    logic            w_release, w_timeout;
    logic [3:0]      w_gnt_nxt;
    logic            w_dwr_nxt;

    // Round-robin search starting just after the last released port.
    always_comb begin
        logic [1:0] v_idx;
        w_win     = '0;
        w_win_vld = 1'b0;
        v_idx     = '0;
        for (int i = 1; i <= 4; i++) begin
            v_idx = r_last + 2'(i);
            if (!w_win_vld && i_req[v_idx]) begin
                w_win     = v_idx;
                w_win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_gidx = '0;
        for (int n = 0; n < 4; n++)
            if (o_gnt[n]) w_gidx = 2'(n);
    end

    assign w_req_g  = |(i_req & o_gnt);
    assign w_wr_g   = |(i_data_wr & o_gnt);
    assign w_data_g = iv_data[int'(w_gidx)*TW +: TW];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == S_WAIT && w_state_nxt == S_WAIT) ? r_cnt + 1'b1 : '0;
            if (w_release) r_last <= w_gidx;
        end
    end

    // Strobe wins over drop, drop wins over timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_release   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: if (w_win_vld) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_wr_g) begin
                    w_state_nxt = S_XFER;
                end else if (!w_req_g) begin
                    w_state_nxt = S_IDLE;
                    w_release   = 1'b1;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_release   = 1'b1;
                    w_timeout   = 1'b1;
                end
            end
            S_XFER: if (!w_wr_g) begin
                w_state_nxt = S_IDLE;
                w_release   = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt = '0;
        w_dwr_nxt = 1'b0;
        case (r_state)
            S_IDLE:         if (w_win_vld) w_gnt_nxt = 4'(1) << w_win;
            S_WAIT, S_XFER: begin
                w_gnt_nxt = w_release ? 4'b0 : o_gnt;
                w_dwr_nxt = w_wr_g;
            end
            default: ;
        endcase
    end

    // ov_data only loads on a granted strobe so it holds the last word otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_gnt     <= '0;
            o_data_wr <= 1'b0;
            ov_data   <= '0;
        end else begin
            o_gnt     <= w_gnt_nxt;
            o_data_wr <= w_dwr_nxt;
            if (w_dwr_nxt) ov_data <= w_data_g;
        end
    end

`ifdef HTD_ARB_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ov_pkt_cnt     <= '0;
            ov_timeout_cnt <= '0;
        end else begin
            if (w_release && r_state == S_XFER) ov_pkt_cnt <= ov_pkt_cnt + 16'd1;
            if (w_timeout) ov_timeout_cnt <= ov_timeout_cnt + 16'd1;
        end
    end
`endif

endmodule
